// File: rtl/regfile_wb_arbiter_if.sv
// Write-back port bundle between the execute/memory producers and the arbiter.
// The ALU result, load-return beat, load-issue mark, decode hazard check and register-file write port all live here.
// master: producer/decode/regfile side; slave: the arbiter itself.
interface regfile_wb_arbiter_if #(
  parameter int REG_DATA_WIDTH = 32,
  parameter int REG_SEL_BITS   = 5
);
  // ALU result path
  logic                      alu_valid;
  logic [REG_SEL_BITS-1:0]   alu_sel;
  logic [REG_DATA_WIDTH-1:0] alu_data;
  logic                      alu_ready;
  // Load-return path
  logic                      ld_valid;
  logic [REG_SEL_BITS-1:0]   ld_sel;
  logic [REG_DATA_WIDTH-1:0] ld_data;
  logic                      ld_ready;
  // Load issue and decode hazard query
  logic                      mark_valid;
  logic [REG_SEL_BITS-1:0]   mark_sel;
  logic [REG_SEL_BITS-1:0]   chk_sel1;
  logic [REG_SEL_BITS-1:0]   chk_sel2;
  logic                      hazard;
  // Register-file write port
  logic                      wEn;
  logic [REG_SEL_BITS-1:0]   write_sel;
  logic [REG_DATA_WIDTH-1:0] write_data;

  modport master (
    output alu_valid, alu_sel, alu_data, input alu_ready,
    output ld_valid, ld_sel, ld_data, input ld_ready,
    output mark_valid, mark_sel, chk_sel1, chk_sel2, input hazard,
    input wEn, write_sel, write_data
  );

  modport slave (
    input alu_valid, alu_sel, alu_data, output alu_ready,
    input ld_valid, ld_sel, ld_data, output ld_ready,
    input mark_valid, mark_sel, chk_sel1, chk_sel2, output hazard,
    output wEn, write_sel, write_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter owning the single register-file write port; merges ALU results with buffered load returns and tracks in-flight loads.
// Latency: winner is written 1 cycle after grant; a load beat is written no earlier than 2 cycles after acceptance.
// Backpressure: ld_ready drops when the load FIFO is full; alu_ready drops for one cycle when a starved load is forced.
// Ports: clock, reset (async active-low), bus (slave modport: alu_*, ld_*, mark_*, chk_sel*, hazard, wEn/write_sel/write_data).
module regfile_wb_arbiter #(
  parameter int REG_DATA_WIDTH = 32,
  parameter int REG_SEL_BITS   = 5,
  parameter int LD_DEPTH       = 2,
  parameter int STARVE_MAX     = 3
) (
  input logic                 clock,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);

  localparam int NREG  = 1 << REG_SEL_BITS;
  localparam int PTR_W = $clog2(LD_DEPTH);
  localparam int CNT_W = $clog2(LD_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [REG_SEL_BITS-1:0]   sel;
    logic [REG_DATA_WIDTH-1:0] data;
  } wb_beat_t;

  // Load-return FIFO storage and pointers
  wb_beat_t               fifo_mem [LD_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       fifo_cnt;
  logic                   fifo_nonempty;
  logic                   fifo_full;
  logic                   push;
  wb_beat_t               head;

  // Arbitration
  logic [STV_W-1:0]       starve_cnt;
  logic [STV_W-1:0]       starve_nxt;
  logic                   force_ld;
  logic                   grant_ld;
  logic                   grant_alu;
  wb_beat_t               win;

  // Busy scoreboard
  logic [NREG-1:0]        busy;
  logic [NREG-1:0]        busy_nxt;

  // Registered write port
  logic                   wen_q;
  logic [REG_SEL_BITS-1:0]   wsel_q;
  logic [REG_DATA_WIDTH-1:0] wdata_q;

  assign fifo_nonempty = (fifo_cnt != '0);
  assign fifo_full     = (fifo_cnt == CNT_W'(LD_DEPTH));
  // Push decision uses the pre-pop full flag: a pop in the same cycle does not open a slot.
  assign push          = bus.ld_valid && !fifo_full;
  assign head          = fifo_mem[rd_ptr];

  assign force_ld  = fifo_nonempty && (starve_cnt >= STV_W'(STARVE_MAX));
  assign grant_ld  = fifo_nonempty && (force_ld || !bus.alu_valid);
  assign grant_alu = bus.alu_valid && !force_ld;
  assign win       = grant_ld ? head : wb_beat_t'{sel: bus.alu_sel, data: bus.alu_data};

  assign bus.alu_ready  = !force_ld;
  assign bus.ld_ready   = !fifo_full;
  assign bus.hazard     = busy[bus.chk_sel1] | busy[bus.chk_sel2];
  assign bus.wEn        = wen_q;
  assign bus.write_sel  = wsel_q;
  assign bus.write_data = wdata_q;

  // Starve counter only accumulates while a load is actually waiting behind the ALU.
  always_comb begin
    starve_nxt = starve_cnt;
    if (grant_ld || !fifo_nonempty) begin
      starve_nxt = '0;
    end else if (grant_alu && (starve_cnt < STV_W'(STARVE_MAX))) begin
      starve_nxt = starve_cnt + STV_W'(1);
    end
  end

  // Clear first, then set, so a same-cycle mark of the retiring index stays busy.
  always_comb begin
    busy_nxt = busy;
    if (grant_ld) begin
      busy_nxt[head.sel] = 1'b0;
    end
    if (bus.mark_valid && (bus.mark_sel != '0)) begin
      busy_nxt[bus.mark_sel] = 1'b1;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= wb_beat_t'{sel: bus.ld_sel, data: bus.ld_data};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      starve_cnt <= '0;
      busy       <= '0;
      wen_q      <= 1'b0;
      wsel_q     <= '0;
      wdata_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (grant_ld) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, grant_ld})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      starve_cnt <= starve_nxt;
      busy       <= busy_nxt;
      // Register 0 is hardwired: its writers are consumed without a write strobe.
      wen_q <= (grant_ld || grant_alu) && (win.sel != '0);
      if (grant_ld || grant_alu) begin
        wsel_q  <= win.sel;
        wdata_q <= win.data;
      end
    end
  end

endmodule
